// File: rtl/id_master_read_stream.sv
// Avalon-MM burst read master: fetches a byte_count-long stream from DDR2 through a
// credit-limited word FIFO and unpacks it little-endian onto a byte valid/ready port.
module id_master_read_stream #(
   parameter int BURST_LEN  = 8,
   parameter int FIFO_DEPTH = 32,
   parameter int ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_address,
   input  logic [31:0]       byte_count,
   output logic              MR_read,
   output logic [ADDR_W-1:0] MR_address,
   output logic [7:0]        MR_burstcount,
   input  logic              MR_waitrequest,
   input  logic              MR_readdatavalid,
   input  logic [31:0]       MR_readdata,
   output logic              byte_valid,
   output logic [7:0]        byte_data,
   input  logic              byte_ready,
   output logic              byte_last,
   output logic              eoi_seen,
   output logic              busy,
   output logic              done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

   state_t            state_q, state_d;
   logic              rd_q, rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        bc_q, bc_d;
   logic [31:0]       wtr_q, wtr_d;
   logic [31:0]       left_q, left_d;
   logic [CW-1:0]     outst_q, outst_d;
   logic [CW-1:0]     used_q, used_d;
   logic [PW-1:0]     wp_q, wp_d;
   logic [PW-1:0]     rp_q, rp_d;
   logic [1:0]        sel_q, sel_d;
   logic              eoi_q, eoi_d;
   logic              pff_q, pff_d;
   logic              done_q, done_d;
   logic [31:0]       mem_q [FIFO_DEPTH];

   logic [7:0]  burst_w;
   logic        can_issue, accept, fifo_wr, fire, pop, last_byte;
   logic [31:0] head;
   logic [7:0]  cur_byte;
   logic        unused_addr_lsb;

   assign unused_addr_lsb = &{1'b0, src_address[1:0]};

   // A burst is only requested when the FIFO can absorb every word already in flight plus this one.
   assign burst_w   = (wtr_q < 32'(BURST_LEN)) ? wtr_q[7:0] : 8'(BURST_LEN);
   assign can_issue = (32'(used_q) + 32'(outst_q) + 32'(burst_w)) <= 32'(FIFO_DEPTH);
   assign accept    = rd_q & ~MR_waitrequest;
   assign fifo_wr   = (state_q == RUN) & MR_readdatavalid;

   // Byte port: a byte moves on byte_valid & byte_ready; data and valid hold while ready is low.
   assign head       = mem_q[rp_q];
   assign cur_byte   = head[{sel_q, 3'b000} +: 8];
   assign last_byte  = (left_q == 32'd1);
   assign byte_valid = (state_q == RUN) && (used_q != '0);
   assign fire       = byte_valid & byte_ready;
   assign pop        = fire & ((sel_q == 2'd3) | last_byte);

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      addr_d  = addr_q;
      bc_d    = bc_q;
      wtr_d   = wtr_q;
      left_d  = left_q;
      outst_d = outst_q;
      used_d  = used_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      sel_d   = sel_q;
      eoi_d   = eoi_q;
      pff_d   = pff_q;
      done_d  = (state_q == FINISH);
      unique case (state_q)
         IDLE: begin
            if (start) begin
               addr_d  = {src_address[ADDR_W-1:2], 2'b00};
               wtr_d   = {2'b00, byte_count[31:2]} + {31'd0, |byte_count[1:0]};
               left_d  = byte_count;
               eoi_d   = 1'b0;
               pff_d   = 1'b0;
               sel_d   = 2'd0;
               state_d = (byte_count == 32'd0) ? FINISH : RUN;
            end
         end
         RUN: begin
            if (rd_q) begin
               if (!MR_waitrequest) begin
                  rd_d   = 1'b0;
                  wtr_d  = wtr_q - 32'(bc_q);
                  addr_d = addr_q + ADDR_W'({bc_q, 2'b00});
               end
            end else if (wtr_q != 32'd0 && can_issue) begin
               rd_d = 1'b1;
               bc_d = burst_w;
            end
            outst_d = outst_q + (accept ? CW'(bc_q) : CW'(0)) - CW'(fifo_wr);
            used_d  = used_q + CW'(fifo_wr) - CW'(pop);
            if (fifo_wr) wp_d = wp_q + PW'(1);
            if (pop) rp_d = rp_q + PW'(1);
            if (fire) begin
               left_d = left_q - 32'd1;
               sel_d  = pop ? 2'd0 : sel_q + 2'd1;
               pff_d  = (cur_byte == 8'hFF);
               if (pff_q && cur_byte == 8'hD9) eoi_d = 1'b1;
               if (last_byte) state_d = FINISH;
            end
         end
         FINISH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         bc_q    <= '0;
         wtr_q   <= '0;
         left_q  <= '0;
         outst_q <= '0;
         used_q  <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         sel_q   <= '0;
         eoi_q   <= 1'b0;
         pff_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         addr_q  <= addr_d;
         bc_q    <= bc_d;
         wtr_q   <= wtr_d;
         left_q  <= left_d;
         outst_q <= outst_d;
         used_q  <= used_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         sel_q   <= sel_d;
         eoi_q   <= eoi_d;
         pff_q   <= pff_d;
         done_q  <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_wr) mem_q[wp_q] <= MR_readdata;
   end

   assert property (@(posedge clk) disable iff (!reset_n) !(fifo_wr && used_q == CW'(FIFO_DEPTH)));

   assign MR_read       = rd_q;
   assign MR_address    = addr_q;
   assign MR_burstcount = bc_q;
   assign byte_data     = byte_valid ? cur_byte : 8'h00;
   assign byte_last     = byte_valid & last_byte;
   assign eoi_seen      = eoi_q;
   assign busy          = (state_q == RUN);
   assign done          = done_q;

endmodule

// File: tb/tb_id_master_read_stream.sv
// Bench for id_master_read_stream: random Avalon slave backed by a byte image, byte-stream
// scoreboard, burst-list model and end-of-transfer checks.
module tb_id_master_read_stream;

   localparam int BL = 8;
   localparam int FD = 32;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] src_address = '0;
   logic [31:0]   byte_count = '0;
   logic          MR_read;
   logic [AW-1:0] MR_address;
   logic [7:0]    MR_burstcount;
   logic          MR_waitrequest = 1'b0;
   logic          MR_readdatavalid = 1'b0;
   logic [31:0]   MR_readdata = '0;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready = 1'b0;
   logic          byte_last;
   logic          eoi_seen;
   logic          busy;
   logic          done;

   id_master_read_stream #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .src_address(src_address),
      .byte_count(byte_count), .MR_read(MR_read), .MR_address(MR_address),
      .MR_burstcount(MR_burstcount), .MR_waitrequest(MR_waitrequest),
      .MR_readdatavalid(MR_readdatavalid), .MR_readdata(MR_readdata),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .byte_last(byte_last), .eoi_seen(eoi_seen), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference memory image and scoreboards.
   logic [7:0]  img [2048];
   logic [31:0] base_al = '0;
   logic [7:0]  exp_q[$];
   logic [39:0] exp_bq[$];
   logic [31:0] rsp_q[$];
   int stall_mode = 0, gap_mode = 0;
   int fetched, burst_err, stab_err, gap_err, byte_err, last_err, got_n, done_cnt;
   int eoi_err, busy_err, exp_n;
   logic mon_en = 1'b0, eoi_m = 1'b0, prev_ff = 1'b0;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      int unsigned o;
      o = a - base_al;
      return {img[(o + 3) % 2048], img[(o + 2) % 2048], img[(o + 1) % 2048], img[o % 2048]};
   endfunction

   // Avalon slave: records accepted bursts against the expected list, returns data in order.
   logic        prev_stall = 1'b0, prev_acc = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [7:0]  prev_bc = '0;
   always @(posedge clk) begin
      if (!reset_n) begin
         rsp_q.delete();
         prev_stall = 1'b0;
         prev_acc = 1'b0;
         #1;
         MR_waitrequest = 1'b0;
         MR_readdatavalid = 1'b0;
      end else begin
         if (prev_stall && (!MR_read || MR_address !== prev_addr || MR_burstcount !== prev_bc))
            stab_err++;
         if (prev_acc && MR_read) gap_err++;
         prev_acc = MR_read && !MR_waitrequest;
         prev_stall = MR_read && MR_waitrequest;
         prev_addr = MR_address;
         prev_bc = MR_burstcount;
         if (prev_acc) begin
            if (exp_bq.size() == 0) burst_err++;
            else begin
               if ({MR_address, MR_burstcount} !== exp_bq[0]) burst_err++;
               void'(exp_bq.pop_front());
            end
            fetched += int'(MR_burstcount);
            for (int i = 0; i < int'(MR_burstcount); i++) rsp_q.push_back(MR_address + 32'(4 * i));
         end
         #1;
         MR_waitrequest = (stall_mode != 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
         if (rsp_q.size() != 0 && (gap_mode == 0 || $urandom_range(0, 2) != 0)) begin
            MR_readdata = word_at(rsp_q.pop_front());
            MR_readdatavalid = 1'b1;
         end else begin
            MR_readdata = $urandom;
            MR_readdatavalid = 1'b0;
         end
      end
   end

   // Byte-side monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         if (eoi_seen !== eoi_m) eoi_err++;
         if (done) begin
            done_cnt++;
            if (busy) busy_err++;
         end
         if (byte_valid && byte_ready) begin
            if (exp_q.size() == 0) byte_err++;
            else begin
               if (byte_data !== exp_q[0]) byte_err++;
               void'(exp_q.pop_front());
            end
            if (byte_last !== (got_n == exp_n - 1)) last_err++;
            got_n++;
            if (prev_ff && byte_data == 8'hD9) eoi_m = 1'b1;
            prev_ff = (byte_data == 8'hFF);
         end
      end
   end

   task automatic fill_img(input bit no_ff);
      for (int i = 0; i < 2048; i++) img[i] = no_ff ? 8'($urandom_range(0, 254)) : 8'($urandom);
   endtask

   // rmode: 0 ready always, 1 random ready, 2 ready held low 200 cycles.
   // special: 0 plain, 1 extra start mid-transfer, 2 async reset mid-transfer.
   task automatic run_xfer(input int n, input logic [31:0] src, input int rmode, input int smode,
                           input int gmode, input int special);
      int w, c, lat;
      logic [31:0] a;
      bit timed_out, eoi_exp;
      base_al = {src[31:2], 2'b00};
      exp_q.delete();
      exp_bq.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(img[i]);
      eoi_exp = 1'b0;
      for (int i = 1; i < n; i++) if (img[i-1] == 8'hFF && img[i] == 8'hD9) eoi_exp = 1'b1;
      w = (n + 3) / 4;
      a = base_al;
      while (w > 0) begin
         c = (w < BL) ? w : BL;
         exp_bq.push_back({a, 8'(c)});
         a = a + 32'(4 * c);
         w = w - c;
      end
      fetched = 0; burst_err = 0; stab_err = 0; gap_err = 0; byte_err = 0; last_err = 0;
      got_n = 0; done_cnt = 0; eoi_err = 0; busy_err = 0; exp_n = n;
      stall_mode = smode;
      gap_mode = gmode;
      @(posedge clk); #1;
      start = 1'b1;
      src_address = src;
      byte_count = 32'(n);
      byte_ready = (rmode != 2);
      @(posedge clk); #1;
      start = 1'b0;
      eoi_m = 1'b0;
      prev_ff = 1'b0;
      mon_en = 1'b1;
      timed_out = 1'b1;
      lat = 0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         if (rmode == 0) byte_ready = 1'b1;
         else if (rmode == 1) byte_ready = 1'($urandom_range(0, 1));
         else byte_ready = (cyc >= 200);
         if (rmode == 2 && cyc == 200) begin
            check_eq("hold_fetch_within_depth", fetched <= FD, 1'b1);
            check_eq("hold_no_bytes", got_n, 0);
         end
         if (special == 1 && cyc == 20) begin
            start = 1'b1;
            byte_count = 32'd5;
            src_address = '0;
         end else start = 1'b0;
         if (special == 2 && cyc == 30) begin
            check_eq("busy_before_reset", busy, 1'b1);
            #2;
            reset_n = 1'b0;
            #1;
            check_eq("async_reset_outputs", {MR_read, MR_address, MR_burstcount, byte_valid,
                     byte_data, byte_last, eoi_seen, busy, done}, '0);
            mon_en = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            reset_n = 1'b1;
            return;
         end
         if (done_cnt != 0) begin
            timed_out = 1'b0;
            lat = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      check_eq("done_timeout", timed_out, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b0;
      check_eq("byte_total", got_n, n);
      check_eq("byte_data_errors", byte_err, 0);
      check_eq("byte_last_errors", last_err, 0);
      check_eq("burst_list_errors", burst_err + exp_bq.size(), 0);
      check_eq("stall_stability_errors", stab_err, 0);
      check_eq("read_gap_errors", gap_err, 0);
      check_eq("done_pulse_count", done_cnt, 1);
      check_eq("busy_during_done", busy_err, 0);
      check_eq("busy_after", busy, 1'b0);
      check_eq("eoi_timing_errors", eoi_err, 0);
      check_eq("eoi_final", eoi_seen, eoi_exp);
      if (n == 0) begin
         check_eq("zero_no_fetch", fetched, 0);
         check_eq("zero_done_latency", lat <= 3, 1'b1);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset_outputs", {MR_read, MR_address, MR_burstcount, byte_valid, byte_data,
               byte_last, eoi_seen, busy, done}, '0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("idle_busy", busy, 1'b0);

      fill_img(1'b0);
      run_xfer(10, 32'h1000, 0, 0, 0, 0);
      fill_img(1'b0);
      run_xfer(256, 32'h1000, 1, 1, 1, 0);
      fill_img(1'b0);
      run_xfer(256, 32'h1000, 2, 0, 0, 0);

      fill_img(1'b1);
      img[100] = 8'hFF;
      img[101] = 8'hD9;
      run_xfer(120, 32'h2000, 1, 0, 0, 0);

      run_xfer(0, 32'h3000, 0, 0, 0, 0);
      fill_img(1'b0);
      run_xfer(100, 32'h1000, 0, 0, 0, 1);

      fill_img(1'b0);
      run_xfer(256, 32'h1000, 1, 1, 1, 2);
      fill_img(1'b0);
      run_xfer(50, 32'h1004, 1, 1, 1, 0);

      fill_img(1'b0);
      run_xfer(64, 32'hFFFF_FFE2, 0, 1, 0, 0);

      for (int k = 0; k < 4; k++) begin
         fill_img(1'b0);
         run_xfer($urandom_range(1, 300), $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 1), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
